inst_encoder: RTL
=================

Name: inst_encoder

Overview:
- Streaming instruction encoder and program loader: the inverse of the 8-bit instruction decoder.
- Accepts one mnemonic per handshake (op select, rs1, rs2, imm), packs it into the 8-bit instruction word and emits it with a sequential write address.
- Sits between the test/boot program source and instruction memory.
- Flags illegal encodings and tracks program fill.

Parameters:
- ADDR_W, 4, instruction-memory address width; program depth = 2**ADDR_W words.
- FILL_WORD, 8'b00000011, canonical NOP (ADD r0,r0) used for padding.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opSel  in  4  mnemonic code (package enum).
- rs1In  in  2  source register 1.
- rs2In  in  2  source register 2.
- immIn  in  4  immediate.
- inValid  in  1  request valid.
- inReady  out  1  encoder can accept.
- instOut  out  8  encoded instruction.
- instAddr  out  ADDR_W  write address of instOut.
- outValid  out  1  instOut/instAddr valid.
- outReady  in  1  sink accepts.
- progDone  in  1  one-cycle pulse: program source finished.
- progFull  out  1  all addresses written.
- errIllegal  out  1  one-cycle pulse: request rejected.
- wordCount  out  ADDR_W+1  words emitted since reset/done.

Behaviour:
- Field packing is fixed:
  - R-type: {rs1,rs2,fn}.
  - I-type: {imm,fn}, with fn[3]=0 canonical.
- fn codes:
  - NOR 1000, NAND 0000, SUB 1011, ADD 0011, SLL 1100, SRL 0100: R-type.
  - BLT 0001, LD 0010, BEQ 0101, ST 0110, JMP 0111: I-type.
  - 1111 is reserved.
- opSel values outside the 11 legal mnemonics are illegal:
  - Accepted and dropped.
  - errIllegal pulses the cycle after acceptance.
  - No word is emitted and the address does not advance.
- FSM states:
  - IDLE (ready for a request).
  - EMIT (output register holds a word until outReady).
  - PAD (emitting FILL_WORD).
  - FULL (terminal until reset).
- Handshake:
  - Transfer happens when valid && ready on a rising edge.
  - inReady = (state==IDLE) || (state==EMIT && outReady), giving 1-word skid and throughput of 1 word/cycle.
  - Latency is 1 cycle from input accept to outValid.
  - instOut/instAddr are held stable while outValid && !outReady.
- instAddr starts at 0 and increments after each output transfer.
  - When the transfer at address 2**ADDR_W-1 completes: progFull=1, state=FULL, inReady=0.
  - No wrap-around.
- wordCount increments per output transfer and saturates at 2**ADDR_W.
- progDone:
  - In IDLE: enters PAD if the feature is enabled, else FULL.
  - In EMIT: the held word is completed first, then the same transition applies.
  - If progDone and inValid are asserted in the same cycle, the request is accepted and encoded first; progDone is latched.
- Illegal request while in EMIT:
  - The held word is unaffected.
  - errIllegal still pulses.
- Reset values: inReady=0 during reset, then 1; outValid=0, instOut=0, instAddr=0, progFull=0, errIllegal=0, wordCount=0, state=IDLE.
- Reset asserted mid-operation aborts any held word immediately; no partial output.

Optional Feature:
- Macro: INST_ENC_NOP_PAD_EN.
- Defined: progDone enters PAD.
  - FILL_WORD is emitted at each remaining address, under the normal outValid/outReady handshake.
  - After the last address, the block goes to FULL; inReady=0 throughout PAD.
- Undefined: PAD does not exist.
  - progDone goes directly to FULL after any held word completes.
  - Remaining addresses are untouched; progFull asserts regardless.

Decomposition:
- Package inst_pkg:
  - opSel enum (11 mnemonics).
  - FN_* 4-bit localparams.
  - FN_RESERVED=4'b1111.
  - is_itype function.
  - FSM state typedef.
- Sub-module inst_pack: purely combinational opSel/fields -> {inst[7:0], legal}, reused by the testbench as a reference model.

Test Plan:
- ADD rs1=2 rs2=1, outReady=1 -> next cycle instOut=8'b10010011, instAddr=0, outValid=1.
- BEQ imm=4'b1010 -> instOut=8'b10100101; then NOR rs1=2 rs2=2 back-to-back -> 8'b10101000 at addr 1, no bubble.
- outReady held low for 3 cycles with a second request pending -> instOut stable, inReady=0; on release, both words delivered in order at addresses 0 and 1.
- Illegal opSel=4'hF -> errIllegal single pulse, outValid stays 0, instAddr unchanged.
- ADDR_W=2:
  - 4 legal words -> progFull=1, inReady=0, wordCount=4.
  - Further inValid is ignored.
- ADDR_W=2, 1 word then progDone:
  - With NOP_PAD_EN: 3 × 8'b00000011 at addresses 1-3, then progFull.
  - Without it: progFull next cycle.
  - Reset mid-PAD: all outputs return to 0.

Source files
------------

// File: rtl/inst_pkg.sv
// rtl/inst_pkg.sv - mnemonic codes, function fields and FSM state type for inst_encoder
package inst_pkg;

  typedef enum logic [3:0] {
    OP_NAND = 4'd0,
    OP_NOR  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_SLL  = 4'd4,
    OP_SRL  = 4'd5,
    OP_BLT  = 4'd6,
    OP_LD   = 4'd7,
    OP_BEQ  = 4'd8,
    OP_ST   = 4'd9,
    OP_JMP  = 4'd10
  } op_sel_e;

  localparam logic [3:0] FN_NAND     = 4'b0000;
  localparam logic [3:0] FN_NOR      = 4'b1000;
  localparam logic [3:0] FN_SUB      = 4'b1011;
  localparam logic [3:0] FN_ADD      = 4'b0011;
  localparam logic [3:0] FN_SLL      = 4'b1100;
  localparam logic [3:0] FN_SRL      = 4'b0100;
  localparam logic [3:0] FN_BLT      = 4'b0001;
  localparam logic [3:0] FN_LD       = 4'b0010;
  localparam logic [3:0] FN_BEQ      = 4'b0101;
  localparam logic [3:0] FN_ST       = 4'b0110;
  localparam logic [3:0] FN_JMP      = 4'b0111;
  localparam logic [3:0] FN_RESERVED = 4'b1111;

  typedef logic [1:0] state_t;

  function automatic logic is_itype(input logic [3:0] fn);
    case (fn)
      FN_BLT, FN_LD, FN_BEQ, FN_ST, FN_JMP: is_itype = 1'b1;
      default:                              is_itype = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/inst_pack.sv
// rtl/inst_pack.sv - combinational mnemonic/field packer into an 8-bit instruction word
// Illegal mnemonics produce inst=0 with legal=0.
module inst_pack
  import inst_pkg::*;
(
  input  logic [3:0] op_sel,
  input  logic [1:0] rs1,
  input  logic [1:0] rs2,
  input  logic [3:0] imm,
  output logic [7:0] inst,
  output logic       legal
);

  logic [3:0] fn;

  always_comb begin
    fn    = FN_RESERVED;
    legal = 1'b1;
    case (op_sel)
      OP_NAND: fn = FN_NAND;
      OP_NOR:  fn = FN_NOR;
      OP_ADD:  fn = FN_ADD;
      OP_SUB:  fn = FN_SUB;
      OP_SLL:  fn = FN_SLL;
      OP_SRL:  fn = FN_SRL;
      OP_BLT:  fn = FN_BLT;
      OP_LD:   fn = FN_LD;
      OP_BEQ:  fn = FN_BEQ;
      OP_ST:   fn = FN_ST;
      OP_JMP:  fn = FN_JMP;
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      inst = 8'h00;
    end else if (is_itype(fn)) begin
      inst = {imm, fn};
    end else begin
      inst = {rs1, rs2, fn};
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - streaming instruction encoder and sequential program loader
// Build macro INST_ENC_NOP_PAD_EN pads the remaining addresses with FILL_WORD after progDone.
module inst_encoder
  import inst_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter logic [7:0]  FILL_WORD = 8'b00000011
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        opSel,
  input  logic [1:0]        rs1In,
  input  logic [1:0]        rs2In,
  input  logic [3:0]        immIn,
  input  logic              inValid,
  output logic              inReady,
  output logic [7:0]        instOut,
  output logic [ADDR_W-1:0] instAddr,
  output logic              outValid,
  input  logic              outReady,
  input  logic              progDone,
  output logic              progFull,
  output logic              errIllegal,
  output logic [ADDR_W:0]   wordCount
);

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EMIT = 2'd1;
  localparam state_t ST_FULL = 2'd3;
`ifdef INST_ENC_NOP_PAD_EN
  localparam state_t ST_PAD     = 2'd2;
  localparam state_t DONE_ST    = ST_PAD;
  localparam logic   DONE_VALID = 1'b1;
`else
  localparam state_t DONE_ST    = ST_FULL;
  localparam logic   DONE_VALID = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [7:0]        inst_q, inst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic [7:0] packed_inst;
  logic       packed_legal;
  logic       accept, xfer, done_any, at_last;

  inst_pack u_pack (
    .op_sel (opSel),
    .rs1    (rs1In),
    .rs2    (rs2In),
    .imm    (immIn),
    .inst   (packed_inst),
    .legal  (packed_legal)
  );

  // The last address never re-arms the skid: nothing may be accepted that could not be written.
  assign at_last  = (addr_q == LAST_ADDR);
  assign inReady  = rst_n && !done_q &&
                    ((state_q == ST_IDLE) || (state_q == ST_EMIT && outReady && !at_last));
  assign accept   = inValid && inReady;
  assign xfer     = out_valid_q && outReady;
  assign done_any = done_q || progDone;

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    addr_d      = addr_q;
    out_valid_d = out_valid_q;
    done_d      = done_q;
    err_d       = accept && !packed_legal;
    count_d     = (xfer && count_q != DEPTH) ? count_q + (ADDR_W+1)'(1) : count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          done_d = done_any;
          if (packed_legal) begin
            inst_d      = packed_inst;
            out_valid_d = 1'b1;
            state_d     = ST_EMIT;
          end
        end else if (done_any) begin
          done_d      = 1'b0;
          state_d     = DONE_ST;
          out_valid_d = DONE_VALID;
          inst_d      = DONE_VALID ? FILL_WORD : inst_q;
        end
      end
      ST_EMIT: begin
        if (xfer) begin
          if (at_last) begin
            state_d     = ST_FULL;
            out_valid_d = 1'b0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (accept && packed_legal) begin
              inst_d = packed_inst;
              done_d = done_any;
            end else if (done_any) begin
              done_d      = 1'b0;
              state_d     = DONE_ST;
              out_valid_d = DONE_VALID;
              inst_d      = DONE_VALID ? FILL_WORD : inst_q;
            end else begin
              state_d     = ST_IDLE;
              out_valid_d = 1'b0;
            end
          end
        end else begin
          done_d = done_any;
        end
      end
`ifdef INST_ENC_NOP_PAD_EN
      ST_PAD: begin
        if (xfer) begin
          if (at_last) begin
            state_d     = ST_FULL;
            out_valid_d = 1'b0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      inst_q      <= 8'h00;
      addr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign instOut    = inst_q;
  assign instAddr   = addr_q;
  assign outValid   = out_valid_q;
  assign progFull   = (state_q == ST_FULL);
  assign errIllegal = err_q;
  assign wordCount  = count_q;

endmodule
